multicycle_datapath: RTL and testbench

- Parametrised multicycle CPU datapath: program counter, MAR, instruction register, 16-entry register file, ALU and a sequencing FSM in one block.
- Talks to an external single-port RAM through a req/ack memory handshake.
- Successor to the fixed, unwired datapath. Adds width/address parameters, wait-state tolerant memory access, conditional branching and halt.
- Top-level core of the microprocessor; the RAM sits outside.

---
 rtl/dp_pkg.sv | 38 +++
 rtl/dp_register_file.sv | 37 +++
 rtl/multicycle_datapath.sv | 173 +++++++++++++++++
 tb/tb_multicycle_datapath.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the multicycle datapath: opcodes, FSM states, instruction fields.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package dp_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_LDI   = 4'h5;
    localparam logic [3:0] OP_LOAD  = 4'h6;
    localparam logic [3:0] OP_STORE = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_JZ    = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Instruction field bit positions within the 16-bit instruction word.
    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int RD_HI = 11;
    localparam int RD_LO = 8;
    localparam int RS_HI = 7;
    localparam int RS_LO = 4;
    localparam int RT_HI = 3;
    localparam int RT_LO = 0;
    localparam int A8_HI = 7;
    localparam int A8_LO = 0;

endpackage

// File: rtl/dp_register_file.sv
// 16-entry register file: two operand read ports, one debug read port, one write port.
// Latency: reads combinational, write lands on the next rising clk edge.
// Backpressure: none; a write is accepted every cycle we is high.
module dp_register_file #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [3:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        ra_sel,
    input  logic [3:0]        rb_sel,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [16];

    assign ra_data  = regs[ra_sel];
    assign rb_data  = regs[rb_sel];
    assign dbg_data = regs[dbg_sel];

    // Storage: clear everything on reset, otherwise a single write per cycle (r0 included).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle CPU core: PC/MAR/IR, register file, inline ALU and FETCH-DECODE-EXEC-MEM-HALT sequencer.
// Latency: 3 cycles per ALU/LDI/jump/NOP, 4 per LOAD/STORE, plus 1 per memory wait cycle.
// Backpressure: mem_req is held until mem_ack; the sequencer stalls in FETCH/MEM while ack is low.
module multicycle_datapath
    import dp_pkg::*;
#(
    parameter int                DATA_W = 16,
    parameter int                ADDR_W = 8,
    parameter logic [ADDR_W-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              zero_flag,
    output logic              halted,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] mar_q;
    logic [15:0]       ir_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] wdata_q;
    logic              zf_q;
    logic              halted_q;

    logic [3:0]        op;
    logic [3:0]        rd;
    logic [3:0]        rs;
    logic [3:0]        rt;
    logic [7:0]        a8;
    logic [ADDR_W-1:0] a8_addr;
    logic              ack;

    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;

    logic [DATA_W-1:0] alu_res;
    logic              alu_wr;
    logic              alu_zf;

    assign op      = ir_q[OP_HI:OP_LO];
    assign rd      = ir_q[RD_HI:RD_LO];
    assign rs      = ir_q[RS_HI:RS_LO];
    assign rt      = ir_q[RT_HI:RT_LO];
    assign a8      = ir_q[A8_HI:A8_LO];
    assign a8_addr = a8[ADDR_W-1:0];

    // The request is a decode of the state so a fetch straight out of reset needs no
    // setup cycle; gating with rst makes an in-flight access drop the moment reset hits.
    assign mem_req   = rst && ((state_q == S_FETCH) || (state_q == S_MEM));
    assign mem_we    = rst && (state_q == S_MEM) && (op == OP_STORE);
    // During FETCH the MAR is loaded from the PC; driving the PC directly covers the
    // first fetch after reset, when the MAR still holds its cleared value.
    assign mem_addr  = (state_q == S_FETCH) ? pc_q : mar_q;
    assign mem_wdata = wdata_q;
    assign ack       = mem_req && mem_ack;

    assign pc        = pc_q;
    assign zero_flag = zf_q;
    assign halted    = halted_q;

    // STORE reads rd as its data operand; everything else reads rs/rt.
    dp_register_file #(.DATA_W(DATA_W)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rd),
        .wdata    (rf_wdata),
        .ra_sel   ((op == OP_STORE) ? rd : rs),
        .rb_sel   (rt),
        .dbg_sel  (dbg_sel),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .dbg_data (dbg_data)
    );

    // ALU: result, whether it is written to rd, and whether it updates the zero flag.
    always_comb begin
        alu_res = '0;
        alu_wr  = 1'b0;
        alu_zf  = 1'b0;
        case (op)
            OP_ADD: begin alu_res = a_q + b_q; alu_wr = 1'b1; alu_zf = 1'b1; end
            OP_SUB: begin alu_res = a_q - b_q; alu_wr = 1'b1; alu_zf = 1'b1; end
            OP_AND: begin alu_res = a_q & b_q; alu_wr = 1'b1; alu_zf = 1'b1; end
            OP_OR:  begin alu_res = a_q | b_q; alu_wr = 1'b1; alu_zf = 1'b1; end
            OP_LDI: begin alu_res = DATA_W'(a8); alu_wr = 1'b1; end
            default: ;
        endcase
    end

    // Register write port: ALU/LDI results in EXEC, LOAD data on the MEM ack.
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = alu_res;
        if (state_q == S_EXEC) begin
            rf_we = alu_wr;
        end else if ((state_q == S_MEM) && (op == OP_LOAD)) begin
            rf_we    = ack;
            rf_wdata = mem_rdata;
        end
    end

    // Sequencer and architectural state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RST_PC;
            mar_q    <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            wdata_q  <= '0;
            zf_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mar_q <= pc_q;
                    if (ack) begin
                        ir_q    <= mem_rdata[15:0];
                        pc_q    <= pc_q + 1'b1;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q     <= ra_data;
                    b_q     <= rb_data;
                    mar_q   <= a8_addr;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    state_q <= S_FETCH;
                    if (alu_zf) begin
                        zf_q <= (alu_res == '0);
                    end
                    case (op)
                        OP_NOP:   ;
                        OP_JMP:   pc_q <= a8_addr;
                        OP_JZ:    if (zf_q) pc_q <= a8_addr;
                        OP_LOAD:  state_q <= S_MEM;
                        OP_STORE: begin wdata_q <= a_q; state_q <= S_MEM; end
                        OP_HALT:  begin halted_q <= 1'b1; state_q <= S_HALT; end
                        default:  ;
                    endcase
                end
                S_MEM: begin
                    if (ack) begin
                        if (op == OP_LOAD) begin
                            zf_q <= (mem_rdata == '0);
                        end
                        state_q <= S_FETCH;
                    end
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: wait-state memory model, program vector table, access scoreboard.
// Latency: checks cycle counts from reset release to halted.
// Backpressure: memory model inserts a programmable number of ack wait cycles per access.
module tb_multicycle_datapath;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [7:0]  pc;
    logic        zero_flag;
    logic        halted;
    logic [3:0]  dbg_sel;
    logic [15:0] dbg_data;

    multicycle_datapath #(.DATA_W(16), .ADDR_W(8), .RST_PC(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc        (pc),
        .zero_flag (zero_flag),
        .halted    (halted),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] data;
    } acc_t;

    typedef struct {
        logic [7:0][15:0] prog;
        int               waits;
        int               cycles;
        logic [3:0]       rsel;
        logic [15:0]      rval;
        logic [7:0]       pc;
        logic             zf;
    } vec_t;

    logic [15:0] mem [256];
    acc_t        exp_q [$];
    acc_t        e;
    vec_t        vt [10];
    int          waits;
    int          wcnt;
    bit          force_ack;
    int          n_cmp;
    int          n_fail;
    int          cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push(input logic we, input logic [7:0] a, input logic [15:0] d);
        exp_q.push_back(acc_t'{we, a, d});
    endfunction

    function automatic vec_t mkv(input logic [15:0] w0, w1, w2, w3, w4, w5,
                                 input int wt, input int cy, input logic [3:0] rs,
                                 input logic [15:0] rv, input logic [7:0] p, input logic z);
        vec_t v;
        v.prog[0] = w0; v.prog[1] = w1; v.prog[2] = w2;
        v.prog[3] = w3; v.prog[4] = w4; v.prog[5] = w5;
        v.prog[6] = 16'hF000; v.prog[7] = 16'hF000;
        v.waits = wt; v.cycles = cy; v.rsel = rs; v.rval = rv; v.pc = p; v.zf = z;
        return v;
    endfunction

    task automatic load_prog(input logic [7:0][15:0] prog);
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        for (int i = 0; i < 8; i++) mem[i] = prog[i];
    endtask

    // Assert reset, then release it on a falling edge.
    task automatic reset_release();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_to_halt(input int maxc, output int c);
        c = 0;
        while (halted !== 1'b1 && c < maxc) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (halted !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL halt_timeout: got halted=%b after %0d cycles required 1", halted, c);
        end
    endtask

    // Memory model: ack after `waits` wait cycles, scoreboard every completed access.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wcnt      = 0;
        forever begin
            @(negedge clk);
            #1;
            if (force_ack) begin
                mem_ack = 1'b1;
            end else if (mem_req === 1'b1) begin
                mem_rdata = mem[mem_addr];
                if (wcnt >= waits) begin
                    mem_ack = 1'b1;
                    wcnt    = 0;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("acc_we", {31'd0, mem_we}, {31'd0, e.we});
                        check("acc_addr", {24'd0, mem_addr}, {24'd0, e.addr});
                        if (e.we) check("acc_wdata", {16'd0, mem_wdata}, {16'd0, e.data});
                    end
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end
        end
    end

    initial begin
        rst       = 1'b0;
        dbg_sel   = '0;
        force_ack = 1'b0;
        waits     = 0;
        n_cmp     = 0;
        n_fail    = 0;

        //            w0        w1        w2        w3        w4        w5     wt  cyc rsel  rval      pc     zf
        vt[0] = mkv(16'h5105, 16'h5203, 16'h1312, 16'hF000, 16'hF000, 16'hF000, 0, 12, 4'd3, 16'h0008, 8'h04, 1'b0);
        vt[1] = mkv(16'h5107, 16'h2211, 16'h9010, 16'hF000, 16'hF000, 16'hF000, 0, 12, 4'd2, 16'h0000, 8'h11, 1'b1);
        vt[2] = mkv(16'h5107, 16'h2210, 16'h9010, 16'hF000, 16'hF000, 16'hF000, 0, 12, 4'd2, 16'h0007, 8'h04, 1'b0);
        vt[3] = mkv(16'h510C, 16'h520A, 16'h3312, 16'h4412, 16'hF000, 16'hF000, 0, 15, 4'd4, 16'h000E, 8'h05, 1'b0);
        vt[4] = mkv(16'h51F0, 16'h520F, 16'h3312, 16'hF000, 16'hF000, 16'hF000, 0, 12, 4'd3, 16'h0000, 8'h04, 1'b1);
        vt[5] = mkv(16'hA123, 16'h55FF, 16'h0000, 16'hF000, 16'hF000, 16'hF000, 0, 12, 4'd5, 16'h00FF, 8'h04, 1'b0);
        vt[6] = mkv(16'h5101, 16'h5202, 16'h2312, 16'hF000, 16'hF000, 16'hF000, 0, 12, 4'd3, 16'hFFFF, 8'h04, 1'b0);
        vt[7] = mkv(16'h515A, 16'h7120, 16'h6420, 16'hF000, 16'hF000, 16'hF000, 0, 14, 4'd4, 16'h005A, 8'h04, 1'b0);
        vt[8] = mkv(16'h515A, 16'h7120, 16'h6420, 16'hF000, 16'hF000, 16'hF000, 3, 32, 4'd4, 16'h005A, 8'h04, 1'b0);
        vt[9] = mkv(16'h5100, 16'h7130, 16'h5201, 16'h1322, 16'h6430, 16'hF000, 0, 20, 4'd4, 16'h0000, 8'h06, 1'b1);

        for (int i = 0; i < 10; i++) begin
            rst = 1'b0;
            load_prog(vt[i].prog);
            waits = vt[i].waits;
            if (i == 1) begin
                push(1'b0, 8'h00, 16'h0); push(1'b0, 8'h01, 16'h0);
                push(1'b0, 8'h02, 16'h0); push(1'b0, 8'h10, 16'h0);
            end
            if (i == 2) begin
                push(1'b0, 8'h00, 16'h0); push(1'b0, 8'h01, 16'h0);
                push(1'b0, 8'h02, 16'h0); push(1'b0, 8'h03, 16'h0);
            end
            if (i == 8) begin
                push(1'b0, 8'h00, 16'h0);  push(1'b0, 8'h01, 16'h0);
                push(1'b1, 8'h20, 16'h5A); push(1'b0, 8'h02, 16'h0);
                push(1'b0, 8'h20, 16'h0);  push(1'b0, 8'h03, 16'h0);
            end
            reset_release();
            run_to_halt(600, cyc);
            check($sformatf("v%0d_cycles", i), cyc, vt[i].cycles);
            check($sformatf("v%0d_pc", i), {24'd0, pc}, {24'd0, vt[i].pc});
            check($sformatf("v%0d_zf", i), {31'd0, zero_flag}, {31'd0, vt[i].zf});
            dbg_sel = vt[i].rsel;
            #1;
            check($sformatf("v%0d_reg", i), {16'd0, dbg_data}, {16'd0, vt[i].rval});
            check($sformatf("v%0d_sb_drain", i), exp_q.size(), 0);
            exp_q.delete();
        end

        // Reset during a stalled fetch: mem_req must drop without waiting for a clock edge.
        rst = 1'b0;
        load_prog(vt[0].prog);
        waits = 3;
        reset_release();
        repeat (2) @(posedge clk);
        #2;
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        check("rst_req_drop", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        check("rst_zf", {31'd0, zero_flag}, 32'd0);
        for (int r = 0; r < 16; r++) begin
            dbg_sel = r[3:0];
            #1;
            check($sformatf("rst_reg%0d", r), {16'd0, dbg_data}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_pc", {24'd0, pc}, 32'h00);
        check("rel_halted", {31'd0, halted}, 32'd0);
        check("rel_req", {31'd0, mem_req}, 32'd1);
        check("rel_addr", {24'd0, mem_addr}, 32'h00);

        // PC wrap: JZ not taken, set Z, JMP 0xFF, NOP at 0xFF, wrap to 0x00, JZ taken to HALT at 5.
        rst = 1'b0;
        waits = 0;
        for (int k = 0; k < 256; k++) mem[k] = 16'hF000;
        mem[8'h00] = 16'h9005;
        mem[8'h01] = 16'h2100;
        mem[8'h02] = 16'h80FF;
        mem[8'hFF] = 16'h0000;
        push(1'b0, 8'h00, 16'h0); push(1'b0, 8'h01, 16'h0); push(1'b0, 8'h02, 16'h0);
        push(1'b0, 8'hFF, 16'h0); push(1'b0, 8'h00, 16'h0); push(1'b0, 8'h05, 16'h0);
        reset_release();
        run_to_halt(600, cyc);
        check("wrap_cycles", cyc, 18);
        check("wrap_pc", {24'd0, pc}, 32'h06);
        check("wrap_sb_drain", exp_q.size(), 0);
        exp_q.delete();

        // Acks arriving while halted must be ignored.
        force_ack = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("halt_req_c%0d", c), {31'd0, mem_req}, 32'd0);
        end
        force_ack = 1'b0;
        check("halt_pc_frozen", {24'd0, pc}, 32'h06);
        check("halt_still", {31'd0, halted}, 32'd1);

        // Reset pulse restarts fetching from the reset PC and the program runs again.
        reset_release();
        #1;
        check("restart_halted", {31'd0, halted}, 32'd0);
        check("restart_req", {31'd0, mem_req}, 32'd1);
        check("restart_addr", {24'd0, mem_addr}, 32'h00);
        run_to_halt(600, cyc);
        check("restart_cycles", cyc, 18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
